// File: rtl/seq_detect_param_if.sv
// Bus interface for seq_detect_param.
//   master : drives enable/pattern/overlap/in/in_valid/clear, observes results
//   slave  : the detector; receives controls and serial data, drives
//            o_out (match pulse), o_match_count, o_sat and o_state
interface seq_detect_param_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             i_enable;
    logic [PAT_W-1:0] i_pattern;
    logic             i_overlap;
    logic             i_in;
    logic             i_in_valid;
    logic             i_clear;
    logic             o_out;
    logic [CNT_W-1:0] o_match_count;
    logic             o_sat;
    logic [1:0]       o_state;

    modport master (
        output i_enable, i_pattern, i_overlap, i_in, i_in_valid, i_clear,
        input  o_out, o_match_count, o_sat, o_state
    );

    modport slave (
        input  i_enable, i_pattern, i_overlap, i_in, i_in_valid, i_clear,
        output o_out, o_match_count, o_sat, o_state
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with runtime-programmable pattern,
// overlapping/non-overlapping modes, registered match pulse and a
// saturating match counter with sticky saturation flag.
// Ports:
//   i_clock : system clock, rising edge
//   i_reset : synchronous active-low reset
//   bus     : seq_detect_param_if.slave (controls, serial data, results)
module seq_detect_param #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input logic               i_clock,
    input logic               i_reset,
    seq_detect_param_if.slave bus
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t            r_state;
    logic [PAT_W-1:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  r_pat;
    logic              r_ovl;
    logic              r_out;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sat;

    state_t            w_state_n;
    logic [PAT_W-1:0]  w_hist_n;
    logic [FILL_W-1:0] w_fill_n;
    logic [PAT_W-1:0]  w_pat_n;
    logic              w_ovl_n;
    logic              w_out_n;
    logic [CNT_W-1:0]  w_cnt_n;
    logic              w_sat_n;
    logic              w_match;

    logic [PAT_W-1:0]  w_hist_sh;
    logic [FILL_W-1:0] w_fill_inc;
    logic              w_fill_full;

    // Candidate history/fill for a sampled bit; newest bit enters at the LSB
    assign w_hist_sh   = {r_hist[PAT_W-2:0], bus.i_in};
    assign w_fill_inc  = (r_fill == FILL_W'(PAT_W)) ? r_fill : r_fill + FILL_W'(1);
    assign w_fill_full = (w_fill_inc == FILL_W'(PAT_W));

    // State and datapath registers
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= '0;
            r_ovl   <= 1'b0;
            r_out   <= 1'b0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_hist  <= w_hist_n;
            r_fill  <= w_fill_n;
            r_pat   <= w_pat_n;
            r_ovl   <= w_ovl_n;
            r_out   <= w_out_n;
            r_cnt   <= w_cnt_n;
            r_sat   <= w_sat_n;
        end
    end

    // Next-state, match detection and counter update
    always_comb begin
        w_state_n = r_state;
        w_hist_n  = r_hist;
        w_fill_n  = r_fill;
        w_pat_n   = r_pat;
        w_ovl_n   = r_ovl;
        w_out_n   = 1'b0;
        w_match   = 1'b0;
        w_cnt_n   = r_cnt;
        w_sat_n   = r_sat;

        case (r_state)
            ST_IDLE: begin
                // Pattern and mode are captured only here; the bit offered
                // on this cycle is not sampled.
                if (bus.i_enable) begin
                    w_pat_n   = bus.i_pattern;
                    w_ovl_n   = bus.i_overlap;
                    w_hist_n  = '0;
                    w_fill_n  = '0;
                    w_state_n = ST_FILL;
                end
            end
            ST_FILL, ST_RUN: begin
                if (!bus.i_enable) begin
                    // Dropping enable discards any match completing now
                    w_hist_n  = '0;
                    w_fill_n  = '0;
                    w_state_n = ST_IDLE;
                end else if (bus.i_in_valid) begin
                    w_hist_n = w_hist_sh;
                    w_fill_n = w_fill_inc;
                    if (w_fill_full) begin
                        w_state_n = ST_RUN;
                    end
                    if (w_fill_full && (w_hist_sh == r_pat)) begin
                        w_match = 1'b1;
                        w_out_n = 1'b1;
                        // Non-overlapping: require PAT_W fresh bits next time
                        if (!r_ovl) begin
                            w_fill_n  = '0;
                            w_state_n = ST_FILL;
                        end
                    end
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        // Clear wins over a simultaneous match; the pulse is unaffected
        if (bus.i_clear) begin
            w_cnt_n = '0;
            w_sat_n = 1'b0;
        end else if (w_match) begin
            if (r_cnt == {CNT_W{1'b1}}) begin
                w_sat_n = 1'b1;
            end else begin
                w_cnt_n = r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.o_out         = r_out;
    assign bus.o_match_count = r_cnt;
    assign bus.o_sat         = r_sat;
    assign bus.o_state       = r_state;

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench for seq_detect_param: two instances (8-bit and 2-bit
// counters) share one stimulus stream and are compared every cycle against
// a queue-based behavioural model, plus directed literal checks.
module tb_seq_detect_param;

    localparam int unsigned PAT_W = 4;
    localparam int MAX_A = 255;
    localparam int MAX_B = 3;

    logic       clk = 1'b0;
    logic       b_rstn, b_en, b_ovl, b_in, b_vld, b_clr;
    logic [3:0] b_pat;

    always #5 clk = ~clk;

    seq_detect_param_if #(.PAT_W(PAT_W), .CNT_W(8)) if_a ();
    seq_detect_param_if #(.PAT_W(PAT_W), .CNT_W(2)) if_b ();

    assign if_a.i_enable = b_en;   assign if_b.i_enable = b_en;
    assign if_a.i_pattern = b_pat; assign if_b.i_pattern = b_pat;
    assign if_a.i_overlap = b_ovl; assign if_b.i_overlap = b_ovl;
    assign if_a.i_in = b_in;       assign if_b.i_in = b_in;
    assign if_a.i_in_valid = b_vld; assign if_b.i_in_valid = b_vld;
    assign if_a.i_clear = b_clr;   assign if_b.i_clear = b_clr;

    seq_detect_param #(.PAT_W(PAT_W), .CNT_W(8)) u_dut_a (
        .i_clock(clk), .i_reset(b_rstn), .bus(if_a.slave));
    seq_detect_param #(.PAT_W(PAT_W), .CNT_W(2)) u_dut_b (
        .i_clock(clk), .i_reset(b_rstn), .bus(if_b.slave));

    int n_tests = 0;
    int n_fail  = 0;
    int p_a     = 0;   // pulses seen on instance A
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_q holds the valid bits collected since the last restart, oldest first
    bit   m_started = 1'b0;
    bit   m_ovl = 1'b0;
    int   m_pat = 0;
    bit   m_q[$];
    int   m_out = 0, m_state = 0;
    int   m_cnt_a = 0, m_cnt_b = 0, m_sat_a = 0, m_sat_b = 0;

    function automatic int qval();
        int v = 0;
        foreach (m_q[i]) v = (v << 1) | int'(m_q[i]);
        return v;
    endfunction

    always @(posedge clk) begin
        bit match;
        match = 1'b0;
        if (!b_rstn) begin
            m_started = 1'b0; m_q.delete(); m_pat = 0; m_ovl = 1'b0;
            m_cnt_a = 0; m_cnt_b = 0; m_sat_a = 0; m_sat_b = 0;
        end else begin
            if (!m_started) begin
                if (b_en) begin
                    m_started = 1'b1; m_pat = int'(b_pat); m_ovl = b_ovl; m_q.delete();
                end
            end else if (!b_en) begin
                m_started = 1'b0; m_q.delete();
            end else if (b_vld) begin
                m_q.push_back(b_in);
                if (m_q.size() > PAT_W) void'(m_q.pop_front());
                if (m_q.size() == PAT_W && qval() == m_pat) begin
                    match = 1'b1;
                    if (!m_ovl) m_q.delete();
                end
            end
            if (b_clr) begin
                m_cnt_a = 0; m_sat_a = 0; m_cnt_b = 0; m_sat_b = 0;
            end else if (match) begin
                if (m_cnt_a == MAX_A) m_sat_a = 1; else m_cnt_a++;
                if (m_cnt_b == MAX_B) m_sat_b = 1; else m_cnt_b++;
            end
        end
        m_out   = int'(match);
        m_state = !m_started ? 0 : (m_q.size() == PAT_W ? 2 : 1);
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_out",   int'(if_a.o_out),         m_out);
            chk("a_state", int'(if_a.o_state),       m_state);
            chk("a_count", int'(if_a.o_match_count), m_cnt_a);
            chk("a_sat",   int'(if_a.o_sat),         m_sat_a);
            chk("b_out",   int'(if_b.o_out),         m_out);
            chk("b_state", int'(if_b.o_state),       m_state);
            chk("b_count", int'(if_b.o_match_count), m_cnt_b);
            chk("b_sat",   int'(if_b.o_sat),         m_sat_b);
            if (if_a.o_out) p_a++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rstn, input logic en, input logic [3:0] pat,
                         input logic ovl, input logic d_in, input logic vld,
                         input logic clr);
        b_rstn = rstn; b_en = en; b_pat = pat; b_ovl = ovl;
        b_in = d_in; b_vld = vld; b_clr = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Reset, then enable with the given pattern/mode (lands in FILL)
    task automatic start(input logic [3:0] pat, input logic ovl);
        drive(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, pat, ovl, 1'b0, 1'b0, 1'b0);
    endtask

    // Send n bits MSB-first on consecutive valid cycles
    task automatic stream(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--)
            drive(1'b1, 1'b1, 4'h0, 1'b0, bits[i], 1'b1, 1'b0);
    endtask

    initial begin
        int p0;
        b_rstn = 1'b0; b_en = 1'b0; b_pat = 4'h0; b_ovl = 1'b0;
        b_in = 1'b0; b_vld = 1'b0; b_clr = 1'b0;

        // Reset state
        drive(1'b0, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_en = 1'b1;
        chk("rst_state", int'(if_a.o_state), 0);
        chk("rst_out",   int'(if_a.o_out), 0);
        chk("rst_count", int'(if_a.o_match_count), 0);
        chk("rst_sat",   int'(if_b.o_sat), 0);

        // 1011 overlapping over 1011011: two pulses
        start(4'b1011, 1'b1);
        p0 = p_a;
        stream(16'b1011011, 7);
        idle();
        chk("ovl_pulses", p_a - p0, 2);
        chk("ovl_count", int'(if_a.o_match_count), 2);

        // Same stream non-overlapping: one pulse, back in FILL
        start(4'b1011, 1'b0);
        p0 = p_a;
        stream(16'b1011, 4);
        chk("novl_state_after_match", int'(if_a.o_state), 1);
        chk("novl_out_after_4th", int'(if_a.o_out), 1);
        stream(16'b011, 3);
        idle();
        chk("novl_pulses", p_a - p0, 1);
        chk("novl_count", int'(if_a.o_match_count), 1);

        // 1111 with seven ones
        start(4'b1111, 1'b1);
        p0 = p_a;
        stream(16'h7F, 7);
        idle();
        chk("ones_ovl_pulses", p_a - p0, 4);
        chk("ones_ovl_count", int'(if_a.o_match_count), 4);
        start(4'b1111, 1'b0);
        p0 = p_a;
        stream(16'h7F, 7);
        idle();
        chk("ones_novl_pulses", p_a - p0, 1);
        chk("ones_novl_count", int'(if_a.o_match_count), 1);

        // 1011 with invalid gaps of 1..3 cycles
        start(4'b1011, 1'b1);
        p0 = p_a;
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] pv;
            pv = 4'b1011;
            drive(1'b1, 1'b1, 4'h0, 1'b0, pv[i], 1'b1, 1'b0);
            if (i == 0) chk("gap_out_after_last", int'(if_a.o_out), 1);
            for (int g = 0; g < 4 - i; g++) idle();
        end
        chk("gap_pulses", p_a - p0, 1);

        // Nine ones on the 2-bit counter, then clear with a further match
        start(4'b1111, 1'b1);
        p0 = p_a;
        stream(16'h1FF, 9);
        idle();
        chk("sat_pulses", p_a - p0, 6);
        chk("sat_count_b", int'(if_b.o_match_count), 3);
        chk("sat_flag_b", int'(if_b.o_sat), 1);
        chk("sat_count_a", int'(if_a.o_match_count), 6);
        drive(1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_count_b", int'(if_b.o_match_count), 0);
        chk("clr_sat_b", int'(if_b.o_sat), 0);
        chk("clr_out_b", int'(if_b.o_out), 1);

        // Enable falling as a match completes: discarded
        start(4'b1011, 1'b1);
        p0 = p_a;
        stream(16'b101, 3);
        drive(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("endrop_out", int'(if_a.o_out), 0);
        chk("endrop_state", int'(if_a.o_state), 0);
        idle();
        chk("endrop_pulses", p_a - p0, 0);
        chk("endrop_count", int'(if_a.o_match_count), 0);

        // Reset mid-stream after 1,0,1 then bit 1: no match
        start(4'b1011, 1'b1);
        stream(16'b101, 3);
        drive(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("mrst_state", int'(if_a.o_state), 0);
        chk("mrst_out", int'(if_a.o_out), 0);
        chk("mrst_count", int'(if_a.o_match_count), 0);
        p0 = p_a;
        drive(1'b1, 1'b1, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("mrst_fill", int'(if_a.o_state), 1);
        drive(1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        chk("mrst_pulses", p_a - p0, 0);

        // Randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            drive(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 29) != 0),
                  4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 39) == 0));
        end
        idle();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
